// File: rtl/delay_buffer_nd.sv
// Multi-channel programmable delay line with valid tracking, ce stall and fill gating.
// Optional flush input is built in when DELAY_BUFFER_FLUSH_EN is defined.
module delay_buffer_nd #(
    parameter int PRECISION = 4,
    parameter int CHANNELS  = 1,
    parameter int MAX_DELAY = 16,
    localparam int DLY_W    = $clog2(MAX_DELAY + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic [DLY_W-1:0]              idelay,
`ifdef DELAY_BUFFER_FLUSH_EN
    input  logic                          iflush,
`endif
    input  logic                          ivalid,
    input  logic [CHANNELS*PRECISION-1:0] idata,
    output logic                          ovalid,
    output logic [CHANNELS*PRECISION-1:0] odata,
    output logic                          ofilled
);

    localparam int W     = CHANNELS * PRECISION;
    localparam int CNT_W = $clog2(MAX_DELAY + 2);

    logic [W-1:0]         sr_data_q [MAX_DELAY];
    logic [W-1:0]         sr_data_d [MAX_DELAY];
    logic [MAX_DELAY-1:0] sr_vld_q, sr_vld_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DLY_W-1:0]     cur_delay_q, cur_delay_d;
    logic                 ovalid_q, ovalid_d;
    logic [W-1:0]         odata_q, odata_d;
    logic                 ofilled_q, ofilled_d;

    logic [DLY_W-1:0]     dclamp;
    logic                 tap_v;
    logic [W-1:0]         tap_d;
    logic                 filled;
    logic                 flush;

    always_comb begin
        dclamp = (idelay > DLY_W'(MAX_DELAY)) ? DLY_W'(MAX_DELAY) : idelay;
        flush  = 1'b0;
`ifdef DELAY_BUFFER_FLUSH_EN
        flush  = iflush;
`endif
        sr_data_d   = sr_data_q;
        sr_vld_d    = sr_vld_q;
        cnt_d       = cnt_q;
        cur_delay_d = cur_delay_q;
        ovalid_d    = ovalid_q;
        odata_d     = odata_q;
        ofilled_d   = ofilled_q;
        tap_v       = ivalid;
        tap_d       = idata;
        filled      = 1'b0;

        // Tap k holds the sample from k+1 ce edges ago; D=0 bypasses storage
        // so the output register alone supplies the single cycle of delay.
        for (int unsigned k = 0; k < MAX_DELAY; k++) begin
            if (DLY_W'(k + 1) == dclamp) begin
                tap_v = sr_vld_q[k];
                tap_d = sr_data_q[k];
            end
        end

        if (ce) begin
            cur_delay_d = dclamp;
            if (dclamp != cur_delay_q)
                cnt_d = CNT_W'(1);
            else if (cnt_q == CNT_W'(MAX_DELAY + 1))
                cnt_d = cnt_q;
            else
                cnt_d = cnt_q + CNT_W'(1);

            sr_data_d[0] = idata;
            sr_vld_d[0]  = ivalid;
            for (int unsigned k = 1; k < MAX_DELAY; k++) begin
                sr_data_d[k] = sr_data_q[k-1];
                sr_vld_d[k]  = sr_vld_q[k-1];
            end

            filled    = (cnt_d >= CNT_W'(dclamp) + CNT_W'(1));
            ofilled_d = filled;
            ovalid_d  = filled & tap_v;
            odata_d   = filled ? tap_d : '0;

            if (flush) begin
                cnt_d     = '0;
                sr_vld_d  = '0;
                ovalid_d  = 1'b0;
                odata_d   = '0;
                ofilled_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_data_q   <= '{default: '0};
            sr_vld_q    <= '0;
            cnt_q       <= '0;
            cur_delay_q <= dclamp;
            ovalid_q    <= 1'b0;
            odata_q     <= '0;
            ofilled_q   <= 1'b0;
        end else begin
            sr_data_q   <= sr_data_d;
            sr_vld_q    <= sr_vld_d;
            cnt_q       <= cnt_d;
            cur_delay_q <= cur_delay_d;
            ovalid_q    <= ovalid_d;
            odata_q     <= odata_d;
            ofilled_q   <= ofilled_d;
        end
    end

    assign ovalid  = ovalid_q;
    assign odata   = odata_q;
    assign ofilled = ofilled_q;

endmodule

// File: tb/tb_delay_buffer_nd.sv
// Directed bench for delay_buffer_nd (CHANNELS=3, PRECISION=4, MAX_DELAY=16).
// Flush steps are included when DELAY_BUFFER_FLUSH_EN is defined.
module tb_delay_buffer_nd;

    localparam int P   = 4;
    localparam int C   = 3;
    localparam int MD  = 16;
    localparam int DW  = $clog2(MD + 1);
    localparam int W   = P * C;

    logic          clk;
    logic          rst;
    logic          ce;
    logic [DW-1:0] idelay;
    logic          ivalid;
    logic [W-1:0]  idata;
    logic          ovalid;
    logic [W-1:0]  odata;
    logic          ofilled;
`ifdef DELAY_BUFFER_FLUSH_EN
    logic          iflush;
`endif

    int checks = 0;
    int errors = 0;

    logic [0:11] cep;
    logic [0:9]  vp;

    delay_buffer_nd #(
        .PRECISION (P),
        .CHANNELS  (C),
        .MAX_DELAY (MD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .idelay  (idelay),
`ifdef DELAY_BUFFER_FLUSH_EN
        .iflush  (iflush),
`endif
        .ivalid  (ivalid),
        .idata   (idata),
        .ovalid  (ovalid),
        .odata   (odata),
        .ofilled (ofilled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat(input int n);
        pat = {4'(n * 3), 4'(n + 7), 4'(n)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic v, input logic [W-1:0] d, input logic f);
        checks++;
        assert (ovalid === v && odata === d && ofilled === f) else begin
            errors++;
            $error("FAIL %s: observed v=%b d=%h f=%b expected v=%b d=%h f=%b",
                   tag, ovalid, odata, ofilled, v, d, f);
        end
    endtask

    initial begin
        rst    = 1'b1;
        ce     = 1'b0;
        idelay = DW'(2);
        ivalid = 1'b0;
        idata  = '0;
`ifdef DELAY_BUFFER_FLUSH_EN
        iflush = 1'b0;
`endif
        cep = 12'b1001_1011_1011;
        vp  = 10'b10110_11111;

        // D=2 ramp; reset applied with ce low
        tick();
        chk("reset", 1'b0, '0, 1'b0);
        rst = 1'b0; ce = 1'b1; ivalid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            idata = pat(i);
            tick();
            if (i <= 2) chk("d2_fill", 1'b0, '0, 1'b0);
            else        chk("d2_run", 1'b1, pat(i - 2), 1'b1);
        end

        // D=0: single register of delay, valid from the first edge
        rst = 1'b1; idelay = DW'(0);
        tick();
        chk("d0_reset", 1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idata = pat(20 + i);
            tick();
            chk("d0_run", 1'b1, pat(20 + i), 1'b1);
        end

        // D=3 with ce toggling; stalled inputs (incl. idelay) are garbage
        rst = 1'b1; idelay = DW'(3);
        tick();
        chk("d3_reset", 1'b0, '0, 1'b0);
        rst = 1'b0;
        begin
            int          k;
            logic        ev, ef;
            logic [W-1:0] ed;
            k = 0; ev = 1'b0; ed = '0; ef = 1'b0;
            for (int i = 0; i < 12; i++) begin
                ce = cep[i];
                if (cep[i]) begin
                    k++;
                    idata = pat(100 + k); idelay = DW'(3); ivalid = 1'b1;
                end else begin
                    idata = pat(200 + i); idelay = DW'(7); ivalid = 1'b0;
                end
                tick();
                if (cep[i]) begin
                    if (k >= 4) begin ev = 1'b1; ed = pat(100 + k - 3); ef = 1'b1; end
                    else        begin ev = 1'b0; ed = '0;               ef = 1'b0; end
                end
                chk("ce_toggle", ev, ed, ef);
            end
        end

        // D=4 steady, then change to 1, then out-of-range 31 -> 16
        ce = 1'b1; ivalid = 1'b1; rst = 1'b1; idelay = DW'(4);
        tick();
        chk("d4_reset", 1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idata = pat(50 + i);
            tick();
            if (i <= 4) chk("d4_fill", 1'b0, '0, 1'b0);
            else        chk("d4_run", 1'b1, pat(50 + i - 4), 1'b1);
        end
        idelay = DW'(1); idata = pat(59);
        tick();
        chk("chg_edge", 1'b0, '0, 1'b0);
        idata = pat(60);
        tick();
        chk("chg_next", 1'b1, pat(59), 1'b1);
        idata = pat(61);
        tick();
        chk("chg_run", 1'b1, pat(60), 1'b1);
        idelay = DW'(31); idata = pat(62);
        tick();
        chk("clamp_edge", 1'b0, '0, 1'b0);
        for (int j = 1; j <= 17; j++) begin
            idata = pat(62 + j);
            tick();
            if (j < 16) chk("clamp_fill", 1'b0, '0, 1'b0);
            else        chk("clamp_run", 1'b1, pat(62 + j - 16), 1'b1);
        end

        // D=5 valid pattern, then mid-stream reset and refill
        rst = 1'b1; idelay = DW'(5);
        tick();
        chk("d5_reset", 1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            ivalid = vp[i-1]; idata = pat(70 + i);
            tick();
            if (i <= 5) chk("d5_fill", 1'b0, '0, 1'b0);
            else        chk("d5_vpat", vp[i-6], pat(70 + i - 5), 1'b1);
        end
        rst = 1'b1; ivalid = 1'b1; idata = pat(99);
        tick();
        chk("rst_mid", 1'b0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            idata = pat(80 + i);
            tick();
            if (i <= 5) chk("refill", 1'b0, '0, 1'b0);
            else        chk("refill_run", 1'b1, pat(81), 1'b1);
        end

`ifdef DELAY_BUFFER_FLUSH_EN
        rst = 1'b1; idelay = DW'(3);
        tick();
        chk("fl_reset", 1'b0, '0, 1'b0);
        rst = 1'b0; ivalid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            idata = pat(120 + i);
            tick();
            if (i <= 3) chk("fl_fill", 1'b0, '0, 1'b0);
            else        chk("fl_run", 1'b1, pat(120 + i - 3), 1'b1);
        end
        iflush = 1'b1; idata = pat(126);
        tick();
        chk("flush_edge", 1'b0, '0, 1'b0);
        iflush = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            idata = pat(126 + j);
            tick();
            if (j < 4) chk("flush_fill", 1'b0, '0, 1'b0);
            else       chk("flush_resume", 1'b1, pat(127), 1'b1);
        end
        ce = 1'b0; iflush = 1'b1; idata = pat(140);
        tick();
        chk("flush_stalled", 1'b1, pat(127), 1'b1);
        ce = 1'b1; iflush = 1'b0; idata = pat(131);
        tick();
        chk("flush_after", 1'b1, pat(128), 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_buffer_nd.md
Name: delay_buffer_nd

Overview:
Multi-channel, runtime-programmable delay line with valid tracking and clock-enable stall. It is the parametrised successor of the fixed-delay scalar delay buffer. It aligns pixel/feature side-streams with compute pipelines whose latency is only known at configuration time. Samples advance only on enabled cycles. Output validity is withheld until the line has refilled after reset or after a delay change.

Parameters:
PRECISION, 4, bit width of one channel sample
CHANNELS, 1, number of parallel channels sharing one delay and one valid
MAX_DELAY, 16, largest programmable delay in ce-cycles (>=1)
DLY_W, $clog2(MAX_DELAY+1), width of delay select (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
ce  input  1  advance enable; 0 = full stall
idelay  input  DLY_W  requested delay D in ce-cycles; sampled only on ce edges
ivalid  input  1  input sample valid
idata  input  CHANNELS*PRECISION  packed channel samples, channel 0 in LSBs
ovalid  output  1  delayed ivalid, gated by fill state
odata  output  CHANNELS*PRECISION  delayed data
ofilled  output  1  line holds D+1 samples of the current regime

Behaviour:
- Edge-level rule: on ce edge t, odata/ovalid take the sample accepted on ce edge t-D. D=0 gives one register of delay. This matches the legacy block, where DELAY=N gives N+1 registers.
- Out-of-range delay: Dclamp = min(idelay, MAX_DELAY). Internal cur_delay holds the active D.
- Reset (rst=1 on an edge, regardless of ce): ovalid=0, odata=0, ofilled=0, all stored valid bits cleared, stored data cleared to 0, cnt=0, cur_delay=Dclamp(idelay).
- Stall: ce=0 holds storage, cnt, cur_delay and all outputs. idelay, ivalid and idata are ignored.
- Fill counter cnt counts ce edges since restart and saturates at MAX_DELAY+1. Each ce edge sets cnt=min(cnt+1, MAX_DELAY+1).
- Filled state: after a ce edge where the new cnt >= cur_delay+1, ofilled=1, ovalid=stored ivalid of edge t-D, and odata=stored data.
- Not filled: ovalid=0, odata=0, ofilled=0.
- Delay change: on a ce edge where Dclamp(idelay) != cur_delay:
  - cur_delay takes the new value and cnt=1. That edge's sample is the first of the new regime.
  - Outputs follow the not-filled rule unless the new D=0, in which case the sample appears immediately, valid.
  - Samples from the old regime never appear with ovalid=1.
- The valid bit travels with the data. Samples with ivalid=0 produce ovalid=0 at the output even when filled. odata still shows their data.
- All CHANNELS shift in lockstep; no per-channel state.
- Storage is MAX_DELAY entries (circular buffer or tapped shift register) plus the output register. Output timing must be identical for every D in 0..MAX_DELAY.
- rst has priority over everything. rst during a fill or mid-stream aborts immediately; there is no partial output.

Optional Feature:
DELAY_BUFFER_FLUSH_EN
- Defined: adds port iflush (input, 1).
  - A ce edge with iflush=1 clears all stored valid bits and sets cnt=0, ovalid=0, odata=0, ofilled=0.
  - That edge's input sample is discarded.
  - If a delay change happens on the same edge, cur_delay still updates; flush semantics apply.
  - rst beats iflush. iflush with ce=0 is ignored.
- Undefined: no iflush port, no flush logic.

Test Plan:
- D=2, CHANNELS=3, PRECISION=4, ce=1, idata ramp 0x001,0x002,... with ivalid=1 from the first edge after reset -> ovalid=0 for edges 1-2; edge 3 onward ovalid=1 with odata=0x001,0x002,... and ofilled=1 from edge 3.
- D=0 -> odata equals the previous cycle's idata, ovalid=1 from the first edge after reset.
- D=3, ce toggled 1,0,0,1,1,0,1,... -> output advances only on ce=1 edges. The sequence matches the ce=1-only reference with D=3, and outputs hold during ce=0.
- D=4, steady stream filled; switch idelay to 1 -> next edge ovalid=0 and ofilled=0; the following edge ovalid=1 with the sample from the change edge. No old-regime samples appear valid. idelay=31 with MAX_DELAY=16 behaves as D=16.
- ivalid pattern 1,0,1,1,0 at D=5 -> identical ovalid pattern 5 ce-edges later. rst asserted mid-stream -> next edge all outputs 0, then refill takes D+1 edges.
- (DELAY_BUFFER_FLUSH_EN) D=3 filled; pulse iflush one ce edge -> outputs 0 that edge and the next 3 edges; ovalid=1 resumes on the 4th edge with the first post-flush sample.
